// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM encodings and helpers shared by the UART RX/TX
// path and the command controller.
//   - uart_state_t     : receiver FSM states
//   - UART_OVERSAMPLE  : ticks per bit (16)
//   - TICK_SAMPLE_A/B/C: tick indices of the three mid-bit samples (7/8/9)
//   - TICK_LAST        : last tick index of a bit (15)
//   - baud_div()       : system clocks per oversample tick, truncated
//   - maj3()           : 2-of-3 majority vote
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    localparam int UART_OVERSAMPLE = 16;

    localparam logic [3:0] TICK_SAMPLE_A = 4'd7;
    localparam logic [3:0] TICK_SAMPLE_B = 4'd8;
    localparam logic [3:0] TICK_SAMPLE_C = 4'd9;
    localparam logic [3:0] TICK_LAST     = 4'd15;

    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
// Counts 0..DIV-1 and raises o_tick for one clock while the count is DIV-1.
// i_clr holds the count at zero so the tick phase can be re-aligned to an
// external event (the start edge on the RX side).
//   i_clk_sys : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_clr     : synchronous clear, suppresses the tick
//   o_tick    : one-cycle tick every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
        end else if (i_clr || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign o_tick = ~i_clr & (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with 16x oversampling.
// The RX pin is synchronised with two flops; a falling edge in IDLE starts
// a frame and re-phases the tick generator to that edge. The start bit is
// re-checked mid-bit, each data/stop bit is the majority of three samples
// taken near the bit centre. Good bytes update a held data bus with a
// one-cycle done strobe; a low stop bit gives a one-cycle framing error and
// the receiver then waits for the line to return high.
//   i_clk_sys   : system clock
//   i_rst_n     : asynchronous active-low reset
//   i_uart_rx   : asynchronous serial input, idle high
//   o_uart_data : last correctly framed byte, held between frames
//   o_rx_done   : one-cycle pulse when o_uart_data is updated
//   o_frame_err : one-cycle pulse when the stop bit is sampled low
//   o_rx_busy   : high from start-edge detection until back in IDLE
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_uart_data,
    output logic                  o_rx_done,
    output logic                  o_frame_err,
    output logic                  o_rx_busy
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic                  rx_meta_reg, rx_s_reg, rx_prev_reg;
    uart_state_t           state_reg, state_next;
    logic [3:0]            tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] sh_reg, sh_next;
    logic [2:0]            samp_reg, samp_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  done_reg, done_next;
    logic                  ferr_reg, ferr_next;
    logic                  busy_reg, busy_next;
    logic                  tick;
    logic                  rx_fall;

    // Held in clear while idle so the first tick lands DIV clocks after
    // the start edge is seen.
    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .i_clr     (state_reg == ST_IDLE),
        .o_tick    (tick)
    );

    assign rx_fall = rx_prev_reg & ~rx_s_reg;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_s_reg     <= 1'b1;
            rx_prev_reg  <= 1'b1;
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            sh_reg       <= '0;
            samp_reg     <= '0;
            data_reg     <= '0;
            done_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            rx_meta_reg  <= i_uart_rx;
            rx_s_reg     <= rx_meta_reg;
            rx_prev_reg  <= rx_s_reg;
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            sh_reg       <= sh_next;
            samp_reg     <= samp_next;
            data_reg     <= data_next;
            done_reg     <= done_next;
            ferr_reg     <= ferr_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        sh_next       = sh_reg;
        samp_next     = samp_reg;
        data_next     = data_reg;
        done_next     = 1'b0;
        ferr_next     = 1'b0;
        busy_next     = busy_reg;

        case (state_reg)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (rx_fall) begin
                    state_next    = ST_START;
                    tick_cnt_next = '0;
                    busy_next     = 1'b1;
                end
            end

            // The whole start bit is counted so that tick_cnt is aligned to
            // bit boundaries in DATA/STOP; the centre sample only rejects
            // glitches.
            ST_START: begin
                if (tick) begin
                    tick_cnt_next = tick_cnt_reg + 4'd1;
                    if (tick_cnt_reg == TICK_SAMPLE_A && rx_s_reg) begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                    end else if (tick_cnt_reg == TICK_LAST) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    tick_cnt_next = tick_cnt_reg + 4'd1;
                    if (tick_cnt_reg == TICK_SAMPLE_A) samp_next[0] = rx_s_reg;
                    if (tick_cnt_reg == TICK_SAMPLE_B) samp_next[1] = rx_s_reg;
                    if (tick_cnt_reg == TICK_SAMPLE_C) samp_next[2] = rx_s_reg;
                    if (tick_cnt_reg == TICK_LAST) begin
                        sh_next      = {maj3(samp_reg), sh_reg[DATA_WIDTH-1:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = ST_STOP;
                        end
                    end
                end
            end

            // Decide on the third sample and leave immediately, so a start
            // edge right at the end of the stop bit is still seen in IDLE.
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_next = tick_cnt_reg + 4'd1;
                    if (tick_cnt_reg == TICK_SAMPLE_A) samp_next[0] = rx_s_reg;
                    if (tick_cnt_reg == TICK_SAMPLE_B) samp_next[1] = rx_s_reg;
                    if (tick_cnt_reg == TICK_SAMPLE_C) begin
                        if (maj3({rx_s_reg, samp_reg[1], samp_reg[0]})) begin
                            data_next  = sh_reg;
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                            busy_next  = 1'b0;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = ST_WAIT_HIGH;
                        end
                    end
                end
            end

            ST_WAIT_HIGH: begin
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign o_uart_data = data_reg;
    assign o_rx_done   = done_reg;
    assign o_frame_err = ferr_reg;
    assign o_rx_busy   = busy_reg;

endmodule
